// File: rtl/sevled_pkg.sv
// rtl/sevled_pkg.sv - shared types, segment masks and hex glyph table for the seven-segment scan driver
package sevled_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } scan_state_t;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_A = 7'h01;
  localparam logic [SEG_W-1:0] SEG_B = 7'h02;
  localparam logic [SEG_W-1:0] SEG_C = 7'h04;
  localparam logic [SEG_W-1:0] SEG_D = 7'h08;
  localparam logic [SEG_W-1:0] SEG_E = 7'h10;
  localparam logic [SEG_W-1:0] SEG_F = 7'h20;
  localparam logic [SEG_W-1:0] SEG_G = 7'h40;

  // Active-high glyph; polarity is applied at the pins by the driver.
  function automatic logic [SEG_W-1:0] hex_glyph(input logic [3:0] nib);
    logic [SEG_W-1:0] g;
    case (nib)
      4'h0:    g = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F;
      4'h1:    g = SEG_B | SEG_C;
      4'h2:    g = SEG_A | SEG_B | SEG_D | SEG_E | SEG_G;
      4'h3:    g = SEG_A | SEG_B | SEG_C | SEG_D | SEG_G;
      4'h4:    g = SEG_B | SEG_C | SEG_F | SEG_G;
      4'h5:    g = SEG_A | SEG_C | SEG_D | SEG_F | SEG_G;
      4'h6:    g = SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
      4'h7:    g = SEG_A | SEG_B | SEG_C;
      4'h8:    g = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
      4'h9:    g = SEG_A | SEG_B | SEG_C | SEG_D | SEG_F | SEG_G;
      4'hA:    g = SEG_A | SEG_B | SEG_C | SEG_E | SEG_F | SEG_G;
      4'hB:    g = SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
      4'hC:    g = SEG_A | SEG_D | SEG_E | SEG_F;
      4'hD:    g = SEG_B | SEG_C | SEG_D | SEG_E | SEG_G;
      4'hE:    g = SEG_A | SEG_D | SEG_E | SEG_F | SEG_G;
      default: g = SEG_A | SEG_E | SEG_F | SEG_G;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/sevled_hex_decode.sv
// rtl/sevled_hex_decode.sv - combinational 4-bit to active-high seven-segment glyph
module sevled_hex_decode
  import sevled_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] glyph
);

  assign glyph = hex_glyph(nibble);

endmodule

// File: rtl/sevled_scan_driver.sv
// rtl/sevled_scan_driver.sv - round-robin seven-segment scanner with gap, lzb and frame-aligned updates
module sevled_scan_driver
  import sevled_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYCLES   = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_lzb,
  output logic [SEG_W-1:0]        o_seg,
  output logic                    o_dp,
  output logic [NUM_DIGITS-1:0]   o_dig,
  output logic                    o_frame
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] SHOW_LAST = CW'(SCAN_DIV - BLANK_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [SEG_W-1:0]      SEG_OFF = {SEG_W{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};

  scan_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n, idx_inc;
  logic          slot_start, frame_start, xfer;

  logic [4*NUM_DIGITS-1:0] shadow_value, disp_value, disp_value_n;
  logic [NUM_DIGITS-1:0]   shadow_dp, disp_dp, disp_dp_n;
  logic                    shadow_lzb, disp_lzb, disp_lzb_n;
  logic                    pending;

  logic [3:0]            nib_sel;
  logic [SEG_W-1:0]      glyph;
  logic [NUM_DIGITS-1:0] blank;
  logic [SEG_W-1:0]      seg_n;
  logic                  dp_n;
  logic [NUM_DIGITS-1:0] dig_n;

  assign idx_inc = (idx == IDX_LAST) ? '0 : idx + 1'b1;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    slot_start = 1'b0;
    if (!i_enable) begin
      state_n = ST_OFF;
      cnt_n   = '0;
      idx_n   = '0;
    end else begin
      case (state)
        ST_OFF: begin
          state_n    = ST_SHOW;
          cnt_n      = '0;
          idx_n      = '0;
          slot_start = 1'b1;
        end
        ST_SHOW: begin
          if (cnt == SHOW_LAST) begin
            cnt_n = '0;
            if (BLANK_CYCLES > 0) begin
              state_n = ST_GAP;
            end else begin
              idx_n      = idx_inc;
              slot_start = 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            state_n    = ST_SHOW;
            cnt_n      = '0;
            idx_n      = idx_inc;
            slot_start = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = ST_OFF;
          cnt_n   = '0;
          idx_n   = '0;
        end
      endcase
    end
  end

  // Shadow is only promoted while dark or on entry to digit 0, so a frame never mixes values.
  assign frame_start  = slot_start && (idx_n == '0);
  assign xfer         = pending && (frame_start || (state == ST_OFF));
  assign disp_value_n = xfer ? shadow_value : disp_value;
  assign disp_dp_n    = xfer ? shadow_dp    : disp_dp;
  assign disp_lzb_n   = xfer ? shadow_lzb   : disp_lzb;

  always_comb begin
    logic run;
    run   = disp_lzb_n;
    blank = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      run      = run && (disp_value_n[4*k +: 4] == 4'd0) && !disp_dp_n[k];
      blank[k] = run;
    end
  end

  assign nib_sel = disp_value_n[{idx_n, 2'b00} +: 4];

  sevled_hex_decode u_hex_decode (
    .nibble (nib_sel),
    .glyph  (glyph)
  );

  always_comb begin
    seg_n = SEG_OFF;
    dp_n  = SEG_ACTIVE_LOW;
    dig_n = DIG_OFF;
    if (state_n == ST_SHOW) begin
      dig_n = (NUM_DIGITS'(1) << idx_n) ^ DIG_OFF;
      if (!blank[idx_n]) begin
        seg_n = glyph ^ SEG_OFF;
        dp_n  = disp_dp_n[idx_n] ^ SEG_ACTIVE_LOW;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= ST_OFF;
      cnt          <= '0;
      idx          <= '0;
      shadow_value <= '0;
      shadow_dp    <= '0;
      shadow_lzb   <= 1'b0;
      disp_value   <= '0;
      disp_dp      <= '0;
      disp_lzb     <= 1'b0;
      pending      <= 1'b0;
      o_seg        <= SEG_OFF;
      o_dp         <= SEG_ACTIVE_LOW;
      o_dig        <= DIG_OFF;
      o_frame      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      disp_value <= disp_value_n;
      disp_dp    <= disp_dp_n;
      disp_lzb   <= disp_lzb_n;
      if (i_load) begin
        shadow_value <= i_value;
        shadow_dp    <= i_dp;
        shadow_lzb   <= i_lzb;
        pending      <= 1'b1;
      end else if (xfer) begin
        pending <= 1'b0;
      end
      o_seg   <= seg_n;
      o_dp    <= dp_n;
      o_dig   <= dig_n;
      o_frame <= frame_start;
    end
  end

endmodule

// File: tb/tb_sevled_scan_driver.sv
// tb/tb_sevled_scan_driver.sv - scoreboard bench for sevled_scan_driver against a cycle-arithmetic model
module tb_sevled_scan_driver;

  localparam int ND    = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int SHOW  = DIV - BLANK;
  localparam int FRAME = ND * DIV;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   value = '0;
  logic [3:0]    dp = '0;
  logic          lzb = 1'b0;
  logic [6:0]    o_seg;
  logic          o_dp;
  logic [3:0]    o_dig;
  logic          o_frame;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // {frame, dp, dig, seg}
  logic [12:0] exp_q [$];

  // Model: time since enable, shadow/pending, and the value owned by the current frame.
  bit          m_on = 0;
  int          m_t = 0;
  bit          m_pend = 0;
  logic [15:0] sh_v = '0, d_v = '0;
  logic [3:0]  sh_dp = '0, d_dp = '0;
  logic        sh_l = 1'b0, d_l = 1'b0;

  sevled_scan_driver #(
    .NUM_DIGITS     (ND),
    .SCAN_DIV       (DIV),
    .BLANK_CYCLES   (BLANK),
    .SEG_ACTIVE_LOW (1'b0),
    .DIG_ACTIVE_LOW (1'b1)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_enable (en),
    .i_load   (load),
    .i_value  (value),
    .i_dp     (dp),
    .i_lzb    (lzb),
    .o_seg    (o_seg),
    .o_dp     (o_dp),
    .o_dig    (o_dig),
    .o_frame  (o_frame)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    int         tn, slot, pos;
    bit         xfer, blk;
    logic [6:0] es;
    logic       ed, ef;
    logic [3:0] eg;
    cycle++;
    tn = -1;
    if (!rst_n) begin
      m_on = 0; m_t = 0; m_pend = 0;
      sh_v = '0; sh_dp = '0; sh_l = 1'b0;
      d_v = '0; d_dp = '0; d_l = 1'b0;
    end else begin
      tn   = en ? (m_on ? m_t + 1 : 0) : -1;
      xfer = m_pend && (!m_on || (tn >= 0 && tn % FRAME == 0));
      if (xfer) begin
        d_v = sh_v; d_dp = sh_dp; d_l = sh_l;
      end
      if (load) begin
        sh_v = value; sh_dp = dp; sh_l = lzb; m_pend = 1;
      end else if (xfer) begin
        m_pend = 0;
      end
      m_on = en;
      m_t  = (tn < 0) ? 0 : tn;
    end
    es = 7'h00; ed = 1'b0; eg = 4'hF; ef = 1'b0;
    if (tn >= 0) begin
      slot = (tn % FRAME) / DIV;
      pos  = tn % DIV;
      ef   = (tn % FRAME == 0);
      if (pos < SHOW) begin
        eg[slot] = 1'b0;
        blk = d_l && (slot > 0);
        for (int j = slot; j < ND; j++)
          if (d_v[4*j +: 4] != 4'd0 || d_dp[j]) blk = 0;
        if (!blk) begin
          es = glyph_tab[d_v[4*slot +: 4]];
          ed = d_dp[slot];
        end
      end
    end
    exp_q.push_back({ef, ed, eg, es});
  end

  always @(negedge clk) begin
    logic [12:0] e, got;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {o_frame, o_dp, o_dig, o_seg};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL outputs cyc=%0d got frame=%b dp=%b dig=%h seg=%h required frame=%b dp=%b dig=%h seg=%h",
                 cycle, got[12], got[11], got[10:7], got[6:0], e[12], e[11], e[10:7], e[6:0]);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic l);
    value = v; dp = d; lzb = l; load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  function automatic logic [15:0] rand_value();
    logic [15:0] v;
    for (int k = 0; k < ND; k++)
      v[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
    return v;
  endfunction

  initial begin
    int r;
    bit hit;
    cyc(4);
    rst_n = 1'b1;
    do_load(16'h12AF, 4'h0, 1'b0);
    cyc(2);
    en = 1'b1;
    cyc(70);
    do_load(16'h0070, 4'h0, 1'b1);
    cyc(70);
    do_load(16'h2222, 4'h0, 1'b0);
    cyc(40);
    do_load(16'h1111, 4'h0, 1'b0);
    cyc(70);

    // Load timed so it is sampled on the digit-0 entry edge.
    hit = 0;
    for (int i = 0; i < 2 * FRAME && !hit; i++) begin
      if (m_on && (m_t % FRAME == FRAME - 1)) hit = 1;
      else cyc(1);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL align_frame_edge got no frame edge within %0d cycles required one", 2 * FRAME);
    end
    do_load(16'h9C3D, 4'h5, 1'b0);
    cyc(70);

    cyc(3);
    en = 1'b0;
    cyc(5);
    en = 1'b1;
    hit = 0;
    for (int i = 0; i < 2 * DIV && !hit; i++) begin
      if (m_on && (m_t % DIV >= SHOW)) hit = 1;
      else cyc(1);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL align_gap got no gap within %0d cycles required one", 2 * DIV);
    end
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(40);

    for (int i = 0; i < 1500; i++) begin
      r     = $urandom_range(0, 999);
      rst_n = (r < 3) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 63) == 0) en = ~en;
      load = ($urandom_range(0, 11) == 0);
      if (load) begin
        value = rand_value();
        dp    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        lzb   = 1'($urandom_range(0, 1));
      end
      cyc(1);
    end

    load  = 1'b0;
    rst_n = 1'b1;
    en    = 1'b0;
    cyc(3);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending entries required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
